// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath.
// Sequences fetch/decode/execute/memory/writeback and drives ALUControl.
module multicycle_control #(
   parameter int MEM_WAIT_MAX = 15
) (
   input  logic       CLK,
   input  logic       Reset,
   input  logic [5:0] Opcode,
   input  logic [5:0] Funct,
   input  logic       MemReady,
   output logic [3:0] ALUop,
   output logic [5:0] FuncCode,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegDst,
   output logic       RegWrite,
   output logic       MemtoReg,
   output logic       PCWrite,
   output logic       PCWriteCond,
   output logic [1:0] PCSource,
   output logic       Illegal,
   output logic       MemTimeout
);

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC_R,
      S_WB_R,
      S_EXEC_I,
      S_WB_I,
      S_MEMADR,
      S_MEMRD,
      S_MEMWR,
      S_WB_MEM,
      S_BRANCH,
      S_JUMP
   } state_t;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_ANDI = 6'b001100;
   localparam logic [5:0] OP_ORI  = 6'b001101;
   localparam logic [5:0] OP_SLTI = 6'b001010;

   localparam int CW = $clog2(MEM_WAIT_MAX + 1);
   // Count value seen during the last permitted idle wait cycle
   localparam logic [CW-1:0] CNT_LAST = CW'(MEM_WAIT_MAX - 1);

   state_t          state;
   state_t          state_n;
   logic [5:0]      op_q;
   logic [5:0]      fn_q;
   logic [CW-1:0]   cnt;
   logic [CW-1:0]   cnt_n;
   logic            waiting;
   logic            timeout;
   logic            load_ir;

   assign waiting = (state == S_FETCH) || (state == S_MEMRD) ||
                    (state == S_MEMWR);
   assign timeout = waiting && !MemReady && (cnt == CNT_LAST);
   assign load_ir = (state == S_FETCH) && MemReady;

   // Idle-wait counter: advances only while stalled, cleared otherwise
   always_comb begin
      cnt_n = '0;
      if (waiting && !MemReady && !timeout)
         cnt_n = cnt + 1'b1;
   end

   // State, instruction latch and wait counter registers
   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         state <= S_FETCH;
         op_q  <= '0;
         fn_q  <= '0;
         cnt   <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         if (load_ir) begin
            op_q <= Opcode;
            fn_q <= Funct;
         end
      end
   end

   // Next-state sequencing
   always_comb begin
      state_n = state;
      unique case (state)
         S_FETCH: begin
            if (MemReady)
               state_n = S_DECODE;
            else if (timeout)
               state_n = S_FETCH;
         end
         S_DECODE: begin
            case (op_q)
               OP_R:    state_n = S_EXEC_R;
               OP_LW:   state_n = S_MEMADR;
               OP_SW:   state_n = S_MEMADR;
               OP_BEQ:  state_n = S_BRANCH;
               OP_J:    state_n = S_JUMP;
               OP_ADDI: state_n = S_EXEC_I;
               OP_ANDI: state_n = S_EXEC_I;
               OP_ORI:  state_n = S_EXEC_I;
               OP_SLTI: state_n = S_EXEC_I;
               default: state_n = S_FETCH;
            endcase
         end
         S_EXEC_R: state_n = S_WB_R;
         S_WB_R:   state_n = S_FETCH;
         S_EXEC_I: state_n = S_WB_I;
         S_WB_I:   state_n = S_FETCH;
         S_MEMADR: begin
            if (op_q == OP_LW)
               state_n = S_MEMRD;
            else if (op_q == OP_SW)
               state_n = S_MEMWR;
            else
               state_n = S_FETCH;
         end
         S_MEMRD: begin
            if (MemReady)
               state_n = S_WB_MEM;
            else if (timeout)
               state_n = S_FETCH;
         end
         S_MEMWR: begin
            if (MemReady || timeout)
               state_n = S_FETCH;
         end
         S_WB_MEM: state_n = S_FETCH;
         S_BRANCH: state_n = S_FETCH;
         S_JUMP:   state_n = S_FETCH;
         default:  state_n = S_FETCH;
      endcase
   end

   // Datapath controls from state and latched instruction; zero in reset
   always_comb begin
      ALUop       = 4'b0000;
      FuncCode    = 6'b000000;
      ALUSrcA     = 1'b0;
      ALUSrcB     = 2'b00;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      RegDst      = 1'b0;
      RegWrite    = 1'b0;
      MemtoReg    = 1'b0;
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      PCSource    = 2'b00;
      Illegal     = 1'b0;
      MemTimeout  = 1'b0;
      if (!Reset) begin
         MemTimeout = timeout;
         unique case (state)
            S_FETCH: begin
               MemRead = !timeout;
               ALUSrcB = 2'b01;
               ALUop   = 4'b0010;
               IRWrite = MemReady;
               PCWrite = MemReady;
            end
            S_DECODE: begin
               ALUSrcB = 2'b11;
               ALUop   = 4'b0010;
               Illegal = !(op_q inside {OP_R, OP_LW, OP_SW, OP_BEQ,
                                        OP_J, OP_ADDI, OP_ANDI,
                                        OP_ORI, OP_SLTI});
            end
            S_EXEC_R: begin
               ALUSrcA  = 1'b1;
               ALUop    = 4'b1111;
               FuncCode = fn_q;
            end
            S_WB_R: begin
               RegDst   = 1'b1;
               RegWrite = 1'b1;
            end
            S_EXEC_I: begin
               ALUSrcA = 1'b1;
               ALUSrcB = 2'b10;
               case (op_q)
                  OP_ANDI: ALUop = 4'b0000;
                  OP_ORI:  ALUop = 4'b0001;
                  OP_SLTI: ALUop = 4'b0111;
                  default: ALUop = 4'b0010;
               endcase
            end
            S_WB_I: begin
               RegWrite = 1'b1;
            end
            S_MEMADR: begin
               ALUSrcA = 1'b1;
               ALUSrcB = 2'b10;
               ALUop   = 4'b0010;
            end
            S_MEMRD: begin
               IorD    = 1'b1;
               MemRead = !timeout;
            end
            S_MEMWR: begin
               IorD     = 1'b1;
               MemWrite = !timeout;
            end
            S_WB_MEM: begin
               RegWrite = 1'b1;
               MemtoReg = 1'b1;
            end
            S_BRANCH: begin
               ALUSrcA     = 1'b1;
               ALUop       = 4'b0110;
               PCWriteCond = 1'b1;
               PCSource    = 2'b01;
            end
            S_JUMP: begin
               PCWrite  = 1'b1;
               PCSource = 2'b10;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed testbench for multicycle_control.
// Compares the full control bundle against hand-built per-state vectors.
module tb_multicycle_control;

   logic       CLK = 1'b0;
   logic       Reset = 1'b1;
   logic [5:0] Opcode = 6'd0;
   logic [5:0] Funct = 6'd0;
   logic       MemReady = 1'b0;
   logic [3:0] ALUop;
   logic [5:0] FuncCode;
   logic       ALUSrcA;
   logic [1:0] ALUSrcB;
   logic       IorD, MemRead, MemWrite, IRWrite, RegDst, RegWrite;
   logic       MemtoReg, PCWrite, PCWriteCond;
   logic [1:0] PCSource;
   logic       Illegal, MemTimeout;
   logic [25:0] outs;

   int n_tests = 0;
   int n_fail = 0;

   multicycle_control #(.MEM_WAIT_MAX(15)) dut (
      .CLK(CLK), .Reset(Reset), .Opcode(Opcode), .Funct(Funct),
      .MemReady(MemReady), .ALUop(ALUop), .FuncCode(FuncCode),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .IorD(IorD),
      .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
      .RegDst(RegDst), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
      .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
      .PCSource(PCSource), .Illegal(Illegal), .MemTimeout(MemTimeout)
   );

   always #5 CLK = ~CLK;

   assign outs = {ALUop, FuncCode, ALUSrcA, ALUSrcB,
                  IorD, MemRead, MemWrite, IRWrite, RegDst, RegWrite,
                  MemtoReg, PCWrite, PCWriteCond,
                  PCSource, Illegal, MemTimeout};

   // ctl = {IorD,MemRead,MemWrite,IRWrite,RegDst,RegWrite,MemtoReg,PCWrite,PCWriteCond}
   function automatic logic [25:0] mk(input logic [3:0] alu,
                                      input logic [5:0] fc,
                                      input logic sa,
                                      input logic [1:0] sb,
                                      input logic [8:0] ctl,
                                      input logic [1:0] pcs,
                                      input logic ill,
                                      input logic to);
      return {alu, fc, sa, sb, ctl, pcs, ill, to};
   endfunction

   localparam logic [25:0] ZERO    = 26'd0;
   localparam logic [25:0] F_IDLE  = mk(4'b0010, 6'd0, 1'b0, 2'b01, 9'b010000000, 2'b00, 1'b0, 1'b0);
   localparam logic [25:0] F_RDY   = mk(4'b0010, 6'd0, 1'b0, 2'b01, 9'b010100010, 2'b00, 1'b0, 1'b0);
   localparam logic [25:0] F_TO    = mk(4'b0010, 6'd0, 1'b0, 2'b01, 9'b000000000, 2'b00, 1'b0, 1'b1);
   localparam logic [25:0] DEC     = mk(4'b0010, 6'd0, 1'b0, 2'b11, 9'b000000000, 2'b00, 1'b0, 1'b0);
   localparam logic [25:0] DEC_ILL = mk(4'b0010, 6'd0, 1'b0, 2'b11, 9'b000000000, 2'b00, 1'b1, 1'b0);
   localparam logic [25:0] EXR_SUB = mk(4'b1111, 6'b100010, 1'b1, 2'b00, 9'b000000000, 2'b00, 1'b0, 1'b0);
   localparam logic [25:0] WBR     = mk(4'b0000, 6'd0, 1'b0, 2'b00, 9'b000011000, 2'b00, 1'b0, 1'b0);
   localparam logic [25:0] EXI_ORI = mk(4'b0001, 6'd0, 1'b1, 2'b10, 9'b000000000, 2'b00, 1'b0, 1'b0);
   localparam logic [25:0] WBI     = mk(4'b0000, 6'd0, 1'b0, 2'b00, 9'b000001000, 2'b00, 1'b0, 1'b0);
   localparam logic [25:0] MADR    = mk(4'b0010, 6'd0, 1'b1, 2'b10, 9'b000000000, 2'b00, 1'b0, 1'b0);
   localparam logic [25:0] MRD     = mk(4'b0000, 6'd0, 1'b0, 2'b00, 9'b110000000, 2'b00, 1'b0, 1'b0);
   localparam logic [25:0] MRD_TO  = mk(4'b0000, 6'd0, 1'b0, 2'b00, 9'b100000000, 2'b00, 1'b0, 1'b1);
   localparam logic [25:0] WBM     = mk(4'b0000, 6'd0, 1'b0, 2'b00, 9'b000001100, 2'b00, 1'b0, 1'b0);
   localparam logic [25:0] MWR     = mk(4'b0000, 6'd0, 1'b0, 2'b00, 9'b101000000, 2'b00, 1'b0, 1'b0);
   localparam logic [25:0] BR      = mk(4'b0110, 6'd0, 1'b1, 2'b00, 9'b000000001, 2'b01, 1'b0, 1'b0);
   localparam logic [25:0] JMP     = mk(4'b0000, 6'd0, 1'b0, 2'b00, 9'b000000010, 2'b10, 1'b0, 1'b0);

   task automatic check(input string tag, input logic [25:0] got,
                        input logic [25:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Drive MemReady, check this cycle's outputs, advance one clock
   task automatic cyc(input logic rdy, input string tag,
                      input logic [25:0] exp);
      MemReady = rdy;
      #1;
      check(tag, outs, exp);
      @(posedge CLK);
      #1;
   endtask

   // Complete a fetch of op/fn, then scramble the bus to prove latching
   task automatic fetch(input logic [5:0] op, input logic [5:0] fn,
                        input string tag);
      Opcode = op;
      Funct  = fn;
      cyc(1'b1, tag, F_RDY);
      Opcode = ~op;
      Funct  = ~fn;
      MemReady = 1'b0;
   endtask

   initial begin
      #2;
      check("reset_hold", outs, ZERO);
      @(posedge CLK);
      #4;
      Reset = 1'b0;
      @(posedge CLK);
      #1;
      cyc(1'b0, "fetch_idle", F_IDLE);

      fetch(6'b000000, 6'b100010, "r_fetch");
      cyc(1'b0, "r_dec", DEC);
      cyc(1'b0, "r_exec", EXR_SUB);
      cyc(1'b0, "r_wb", WBR);
      cyc(1'b0, "r_back", F_IDLE);

      fetch(6'b001101, 6'b100101, "ori_fetch");
      cyc(1'b0, "ori_dec", DEC);
      cyc(1'b0, "ori_exec", EXI_ORI);
      cyc(1'b0, "ori_wb", WBI);
      cyc(1'b0, "ori_back", F_IDLE);

      fetch(6'b100011, 6'd0, "lw_fetch");
      cyc(1'b0, "lw_dec", DEC);
      cyc(1'b0, "lw_adr", MADR);
      for (int i = 0; i < 3; i++)
         cyc(1'b0, $sformatf("lw_rd_wait%0d", i), MRD);
      cyc(1'b1, "lw_rd_done", MRD);
      cyc(1'b0, "lw_wb", WBM);
      cyc(1'b0, "lw_back", F_IDLE);

      fetch(6'b101011, 6'd0, "sw_fetch");
      cyc(1'b0, "sw_dec", DEC);
      cyc(1'b0, "sw_adr", MADR);
      cyc(1'b1, "sw_wr", MWR);
      cyc(1'b0, "sw_back", F_IDLE);

      fetch(6'b000100, 6'd0, "beq_fetch");
      cyc(1'b0, "beq_dec", DEC);
      cyc(1'b0, "beq_br", BR);
      cyc(1'b0, "beq_back", F_IDLE);

      fetch(6'b000010, 6'd0, "j_fetch");
      cyc(1'b0, "j_dec", DEC);
      cyc(1'b0, "j_jump", JMP);
      cyc(1'b0, "j_back", F_IDLE);

      fetch(6'b111111, 6'd0, "ill_fetch");
      cyc(1'b0, "ill_dec", DEC_ILL);
      for (int i = 1; i <= 14; i++)
         cyc(1'b0, $sformatf("fto_wait%0d", i), F_IDLE);
      cyc(1'b0, "fto_pulse", F_TO);
      cyc(1'b0, "fto_after", F_IDLE);
      for (int i = 2; i <= 14; i++)
         cyc(1'b0, $sformatf("edge_wait%0d", i), F_IDLE);
      fetch(6'b000010, 6'd0, "edge_ready");
      cyc(1'b0, "edge_dec", DEC);
      cyc(1'b0, "edge_jump", JMP);
      cyc(1'b0, "edge_back", F_IDLE);

      fetch(6'b100011, 6'd0, "lwto_fetch");
      cyc(1'b0, "lwto_dec", DEC);
      cyc(1'b0, "lwto_adr", MADR);
      for (int i = 1; i <= 14; i++)
         cyc(1'b0, $sformatf("lwto_wait%0d", i), MRD);
      cyc(1'b0, "lwto_pulse", MRD_TO);
      cyc(1'b0, "lwto_fetch_back", F_IDLE);

      fetch(6'b100011, 6'd0, "rst_fetch_lw");
      cyc(1'b0, "rst_dec", DEC);
      cyc(1'b0, "rst_adr", MADR);
      #1;
      check("rst_pre", outs, MRD);
      #1;
      Reset = 1'b1;
      #1;
      check("rst_async", outs, ZERO);
      @(posedge CLK);
      #1;
      check("rst_held", outs, ZERO);
      #2;
      Reset = 1'b0;
      @(posedge CLK);
      #1;
      cyc(1'b0, "rst_fetch", F_IDLE);
      cyc(1'b0, "rst_fetch2", F_IDLE);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
